uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Transmit-side sequencer for the UART.
- Owns the bit-period (baud) timer and the frame state machine.
- Drives the team's existing 4-bit bit counter through its CLR/INC controls and reads its Q back to select the data bit.
- Produces the serial TX line plus BUSY/DONE handshake to the host logic.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 19_200, line rate in bits/s; DIV = CLK_FREQ/BAUD_RATE cycles per bit (integer, DIV >= 2).
- PARITY, 1, parity mode: 0 = none, 1 = odd, 2 = even.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- SEND  in  1  request to transmit DIN; level-sensitive, host holds until DONE.
- DIN  in  8  byte to transmit; sampled only on the IDLE->START transition.
- BIT_Q  in  4  current value of the external bit counter.
- BIT_CLR  out  1  clear command to the bit counter (counter loads 0 next edge).
- BIT_INC  out  1  increment command to the bit counter.
- TX  out  1  serial line; idle high.
- BUSY  out  1  high while a frame is on the line (START..STOP).
- DONE  out  1  high in ACK state.

Behaviour:
- Reset (RST_N=0, async): state=IDLE, timer=0, data reg=0.
  - TX=1, BUSY=0, DONE=0, BIT_CLR=1, BIT_INC=0.
  - Effect is immediate, including mid-frame.
- Baud timer: width $clog2(DIV).
  - Held at 0 in IDLE and ACK; otherwise increments each cycle.
  - tick = (timer == DIV-1); timer wraps to 0 on tick.
  - Also cleared on every state change.
- States (Moore outputs):
  - IDLE: TX=1, BIT_CLR=1.
    - SEND=1 -> latch DIN into data reg, compute parity bit, go START.
    - Odd parity: par = ~^DIN. Even parity: par = ^DIN.
  - START: TX=0, BUSY=1, BIT_CLR=1. tick -> BITS.
  - BITS: TX=data[BIT_Q[2:0]], BUSY=1. On tick:
    - If BIT_Q==7: BIT_INC=1, go PAR (PARITY!=0) or STOP (PARITY==0).
    - Else: BIT_INC=1, stay in BITS.
  - PAR: TX=par, BUSY=1. tick -> STOP.
  - STOP: TX=1, BUSY=1. tick -> ACK.
  - ACK: TX=1, DONE=1, BIT_CLR=1. SEND=0 -> IDLE; SEND=1 -> stay in ACK.
- BIT_INC is combinational (state==BITS && tick): exactly one cycle per data bit.
- BIT_CLR and BIT_INC are never asserted together.
- The counter registers INC on the same edge the timer wraps, so the next bit period sees the incremented BIT_Q.
- TX, BUSY and DONE decode only from registered values (state, data reg, BIT_Q), never from inputs.
- Latency and frame length:
  - TX falls on the edge that samples SEND=1 in IDLE.
  - Frame lasts (10 + (PARITY!=0)) * DIV cycles from START entry to ACK entry.
- Bit order is LSB first.
- DIN and SEND changes mid-frame are ignored.
- A new frame requires SEND to drop for at least one cycle (passing through ACK->IDLE).
- BIT_Q values 8..15 in BITS are not produced in normal use; only BIT_Q[2:0] is used for the index.

Decomposition:
- uart_pkg holds:
  - tx_state_t enum {IDLE, START, BITS, PAR, STOP, ACK}.
  - Parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - Function baud_div(clk_freq, baud).
- One sub-module: baud_timer (parameter DIV; ports CLK, RST_N, CLR, TICK).

Test Plan (CLK_FREQ=16, BAUD_RATE=1, so DIV=16; bench instantiates the team 4-bit counter on BIT_CLR/BIT_INC/BIT_Q):
- Reset: RST_N=0 for 3 cycles -> TX=1, BUSY=0, DONE=0, BIT_CLR=1, BIT_INC=0, BIT_Q=0 after the first edge.
- PARITY=1, DIN=0x55, SEND pulse:
  - TX per 16-cycle slot = 0,1,0,1,0,1,0,1,0,1(par),1.
  - BIT_INC pulses exactly 8 times.
  - DONE rises 176 cycles after TX falls.
- SEND held high through DONE: no second start bit while SEND=1. SEND=0 for 1 cycle, then SEND=1 -> new frame starts, BUSY=1.
- DIN changed from 0x55 to 0xFF at bit 3: line still carries the 0x55 pattern and parity 1.
- PARITY=0, DIN=0xA3 -> data bits 1,1,0,0,0,1,0,1, stop at slot 9, DONE after 160 cycles.
- RST_N=0 during bit 4 -> TX=1 and BUSY=0 before the next edge; after release, SEND with 0x0F -> complete clean frame with BIT_Q starting from 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit types, parity modes and baud divisor helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, BITS, PAR, STOP, ACK} tx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_if: host handshake, serial line and bit-counter hookup of the transmitter
interface uart_tx_if;
  logic       send;
  logic [7:0] din;
  logic [3:0] bit_q;
  logic       bit_clr;
  logic       bit_inc;
  logic       tx;
  logic       busy;
  logic       done;
  modport master (output send, din, bit_q, input bit_clr, bit_inc, tx, busy, done);
  modport slave  (input send, din, bit_q, output bit_clr, bit_inc, tx, busy, done);
endinterface

// File: rtl/uart_tx_ctrl_baud_timer.sv
// baud_timer: bit-period counter, ticks on its last cycle and wraps to 0
module baud_timer #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer driving the external bit counter and the TX line
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 19_200,
    parameter int PARITY    = 1
) (
    input logic     clk,
    input logic     rst_n,
    uart_tx_if.slave u
);
    localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
    tx_state_t  state, nxt;
    logic [7:0] data;
    logic       par;
    logic       tick;
    logic       clr;
    baud_timer #(.DIV(DIV)) timer (.clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            par   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && u.send) begin
                data <= u.din;
                par  <= (PARITY == PAR_EVEN) ? ^u.din : ~^u.din;
            end
        end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = u.send ? START : IDLE;
            START:   nxt = tick ? BITS : START;
            BITS:    nxt = !tick ? BITS : (u.bit_q != 4'd7) ? BITS : (PARITY != PAR_NONE) ? PAR : STOP;
            PAR:     nxt = tick ? STOP : PAR;
            STOP:    nxt = tick ? ACK : STOP;
            ACK:     nxt = u.send ? ACK : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // timer restarts every state so each phase gets a full bit period
    assign clr       = state == IDLE || state == ACK || nxt != state;
    assign u.tx      = state == START ? 1'b0 : state == BITS ? data[u.bit_q[2:0]] : state == PAR ? par : 1'b1;
    assign u.busy    = state == START || state == BITS || state == PAR || state == STOP;
    assign u.done    = state == ACK;
    assign u.bit_clr = state == IDLE || state == START || state == ACK;
    assign u.bit_inc = state == BITS && tick;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl with odd and no-parity instances
module tb_uart_tx_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   inc1 = 0;
    int   inc0 = 0;
    logic both_seen = 1'b0;
    logic exp_q[$];
    uart_tx_if u1 ();
    uart_tx_if u0 ();
    uart_tx_ctrl #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(1)) dut1 (.clk(clk), .rst_n(rst_n), .u(u1));
    uart_tx_ctrl #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(0)) dut0 (.clk(clk), .rst_n(rst_n), .u(u0));
    always #5 clk = ~clk;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) u1.bit_q <= '0;
        else if (u1.bit_clr) u1.bit_q <= '0;
        else if (u1.bit_inc) u1.bit_q <= u1.bit_q + 4'd1;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) u0.bit_q <= '0;
        else if (u0.bit_clr) u0.bit_q <= '0;
        else if (u0.bit_inc) u0.bit_q <= u0.bit_q + 4'd1;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (u1.bit_inc) inc1 <= inc1 + 1;
        if (u0.bit_inc) inc0 <= inc0 + 1;
        if ((u1.bit_clr && u1.bit_inc) || (u0.bit_clr && u0.bit_inc)) both_seen <= 1'b1;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic run_frame(input bit p, input logic [7:0] d, input bit hold, input bit chg);
        int t0, n, b;
        n = p ? 11 : 10;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (p) exp_q.push_back(~^d);
        exp_q.push_back(1'b1);
        @(posedge clk); #1;
        chk("idle_busy", p ? u1.busy : u0.busy, 0);
        chk("idle_tx", p ? u1.tx : u0.tx, 1);
        if (p) begin u1.send = 1'b1; u1.din = d; end
        else begin u0.send = 1'b1; u0.din = d; end
        b = p ? inc1 : inc0;
        @(posedge clk); #1;
        t0 = cyc;
        chk("tx_fall", p ? u1.tx : u0.tx, 0);
        chk("busy_start", p ? u1.busy : u0.busy, 1);
        for (int k = 0; k < n; k++) begin
            repeat (k == 0 ? 8 : 16) @(posedge clk);
            #1;
            if (!hold && k == 0) begin u1.send = 1'b0; u0.send = 1'b0; end
            if (chg && k == 4) begin u1.din = 8'hFF; u0.din = 8'hFF; end
            chk($sformatf("slot%0d", k), p ? u1.tx : u0.tx, exp_q.pop_front());
        end
        while (!(p ? u1.done : u0.done) && cyc - t0 < 400) begin
            @(posedge clk); #1;
        end
        chk("done_lat", cyc - t0, n * 16);
        chk("inc_cnt", (p ? inc1 : inc0) - b, 8);
        if (hold) begin
            repeat (40) @(posedge clk);
            #1;
            chk("hold_done", p ? u1.done : u0.done, 1);
            chk("hold_tx", p ? u1.tx : u0.tx, 1);
            chk("hold_busy", p ? u1.busy : u0.busy, 0);
            u1.send = 1'b0;
            u0.send = 1'b0;
        end else begin
            @(posedge clk); #1;
            chk("done_drop", p ? u1.done : u0.done, 0);
        end
    endtask
    initial begin
        u1.send = 1'b0; u1.din = '0;
        u0.send = 1'b0; u0.din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", u1.tx, 1);
        chk("rst_busy", u1.busy, 0);
        chk("rst_done", u1.done, 0);
        chk("rst_clr", u1.bit_clr, 1);
        chk("rst_inc", u1.bit_inc, 0);
        chk("rst_q", u1.bit_q, 0);
        chk("rst_tx0", u0.tx, 1);
        rst_n = 1'b1;
        run_frame(1, 8'h55, 1, 0);
        run_frame(1, 8'h55, 0, 1);
        run_frame(0, 8'hA3, 0, 0);
        @(posedge clk); #1;
        u1.send = 1'b1; u1.din = 8'h55;
        @(posedge clk); #1;
        repeat (88) @(posedge clk);
        #1;
        u1.send = 1'b0;
        chk("mid_busy", u1.busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_tx", u1.tx, 1);
        chk("abort_busy", u1.busy, 0);
        chk("abort_clr", u1.bit_clr, 1);
        chk("abort_q", u1.bit_q, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(1, 8'h0F, 0, 0);
        chk("clr_inc_excl", both_seen, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
